i2c_target_regs: RTL and testbench

Synthesizable I2C target (slave) with an internal byte-wide register file, built as the parametrised successor to the behavioural I2C slave model used in the SoC I2C benches. It samples raw SCL/SDA from the pads through a synchroniser, ACKs or NACKs addresses and register pointers, and supports multi-byte writes and reads with pointer auto-increment and wrap. A host-side port gives the core direct access to the same registers. It sits on the board-side of the TinyQV I2C master, either in-chip for loopback or as a peripheral target.

---
 rtl/i2c_target_regs.sv | 192 +++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register file, pointer auto-increment/wrap and a host-side access port.
// Latency: SYNC_STAGES+1 clk from pad edge to action; no backpressure, SCL phases must be >= SYNC_STAGES+3 clk.
module i2c_target_regs #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h44,
    parameter logic [6:0] ADDR_MASK   = 7'h00,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          nack_stb,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]             shreg;
    logic [7:0]             rx_byte;
    logic [3:0]             bit_cnt;
    logic                   rw;
    logic [AW-1:0]          ptr;
    logic [AW-1:0]          ptr_next;
    logic                   addr_match, ptr_ok, host_in_range;
    logic [7:0]             regs [NUM_REGS];

    // Bus idles high, so synchronisers reset to 1 to avoid a phantom START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & ~sda_s & sda_d;
    assign stop_det  = scl_s & scl_d & sda_s & ~sda_d;

    assign rx_byte       = {shreg[6:0], sda_s};
    assign addr_match    = ((rx_byte[7:1] ^ SLAVE_ADDR) & ~ADDR_MASK) == 7'd0;
    assign ptr_ok        = {1'b0, rx_byte} < 9'(NUM_REGS);
    assign ptr_next      = (ptr == AW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
    assign host_in_range = {1'b0, host_addr} < (AW+1)'(NUM_REGS);
    assign host_rdata    = host_in_range ? regs[host_addr] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            nack_stb <= 1'b0;
            shreg    <= 8'h00;
            bit_cnt  <= 4'd0;
            rw       <= 1'b0;
            ptr      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            wr_stb   <= 1'b0;
            nack_stb <= 1'b0;
            // Host write first so a same-index I2C commit below overrides it.
            if (host_we && host_in_range) regs[host_addr] <= host_wdata;

            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rw <= rx_byte[0];
                            if (addr_match) begin
                                state <= ADDR_ACK;
                                busy  <= 1'b1;
                            end else begin
                                state    <= IGNORE;
                                nack_stb <= 1'b1;
                            end
                        end
                    end
                    // First fall drives the ACK, second fall releases it (or starts read data).
                    ADDR_ACK: if (scl_fall) begin
                        bit_cnt <= 4'd0;
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw) begin
                            shreg  <= regs[ptr];
                            sda_oe <= ~regs[ptr][7];
                            state  <= RDATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= PTR;
                        end
                    end
                    PTR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (ptr_ok) begin
                                ptr   <= rx_byte[AW-1:0];
                                state <= PTR_ACK;
                            end else begin
                                nack_stb <= 1'b1;
                                state    <= IGNORE;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        bit_cnt <= 4'd0;
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            regs[ptr] <= rx_byte;
                            wr_stb    <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= rx_byte;
                            ptr       <= ptr_next;
                            state     <= WDATA_ACK;
                        end
                    end
                    RDATA: if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= RDATA_ACK;
                        end else begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end
                    // Pointer advances after every byte read; only a master ACK continues.
                    RDATA_ACK: if (scl_rise) begin
                        ptr <= ptr_next;
                        if (sda_s) state <= IGNORE;
                    end else if (scl_fall) begin
                        shreg   <= regs[ptr];
                        sda_oe  <= ~regs[ptr][7];
                        bit_cnt <= 4'd0;
                        state   <= RDATA;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C master on a wired-AND bus, host-port read tables and corner sequences.
module tb_i2c_target_regs;

    localparam int P = 8;

    typedef struct { logic [3:0] addr; logic [7:0] exp; } hv_t;
    typedef struct { logic [6:0] addr; logic exp_ack; } mv_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1, sel = 1'b0;
    logic [3:0] host_addr = 4'd0, host_addr_b = 4'd0;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = 8'h00;

    logic       oe_a, wr_stb, nack_stb, busy;
    logic [7:0] rdata_a, wr_data;
    logic [3:0] wr_addr;
    logic       oe_b, wr_stb_b, nack_b, busy_b;
    logic [7:0] rdata_b, wr_data_b;
    logic [3:0] wr_addr_b;

    logic scl_a, sda_a, scl_b, sda_b, sda_bus;
    assign scl_a   = sel ? 1'b1 : scl_m;
    assign sda_a   = (sel ? 1'b1 : sda_m) & ~oe_a;
    assign scl_b   = sel ? scl_m : 1'b1;
    assign sda_b   = (sel ? sda_m : 1'b1) & ~oe_b;
    assign sda_bus = sel ? sda_b : sda_a;

    i2c_target_regs dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_a), .sda_i(sda_a), .sda_oe(oe_a),
        .host_addr(host_addr), .host_rdata(rdata_a), .host_we(host_we), .host_wdata(host_wdata),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .nack_stb(nack_stb), .busy(busy)
    );

    i2c_target_regs #(.ADDR_MASK(7'h03)) dut_mask (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_b), .sda_i(sda_b), .sda_oe(oe_b),
        .host_addr(host_addr_b), .host_rdata(rdata_b), .host_we(1'b0), .host_wdata(8'h00),
        .wr_stb(wr_stb_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .nack_stb(nack_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int nack_cnt = 0, nack_b_cnt = 0, wr_b_cnt = 0;
    bit oe_seen = 1'b0, busy_seen = 1'b0;
    int wq_addr[$], wq_data[$];

    always @(negedge clk) begin
        if (wr_stb) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
        end
        if (nack_stb) nack_cnt++;
        if (nack_b) nack_b_cnt++;
        if (wr_stb_b) wr_b_cnt++;
        if (oe_a) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;
        cyc(P);
        scl_m = 1'b1;
        cyc(P/2);
        s = sda_bus;
        cyc(P/2);
        scl_m = 1'b0;
        cyc(2);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; cyc(P);
        scl_m = 1'b1; cyc(P);
        sda_m = 1'b0; cyc(P);
        scl_m = 1'b0; cyc(2);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(P);
        scl_m = 1'b1; cyc(P);
        sda_m = 1'b1; cyc(P);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~mack, s);
    endtask

    hv_t        hv [8];
    mv_t        mv [6];
    logic       ack, coll;
    logic [7:0] d;
    int         n0;

    initial begin
        hv[0] = '{4'd0,  8'h22}; hv[1] = '{4'd1,  8'h33};
        hv[2] = '{4'd2,  8'h00}; hv[3] = '{4'd3,  8'hA5};
        hv[4] = '{4'd4,  8'h77}; hv[5] = '{4'd5,  8'hC3};
        hv[6] = '{4'd14, 8'h00}; hv[7] = '{4'd15, 8'h11};
        mv[0] = '{7'h44, 1'b1}; mv[1] = '{7'h45, 1'b1}; mv[2] = '{7'h46, 1'b1};
        mv[3] = '{7'h47, 1'b1}; mv[4] = '{7'h48, 1'b0}; mv[5] = '{7'h43, 1'b0};

        cyc(4);
        rst_n = 1'b1;
        cyc(4);
        check("rst_sda_oe", oe_a, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_nack_stb", nack_stb, 0);
        check("rst_rdata0", rdata_a, 8'h00);

        // Unmatched address
        oe_seen = 1'b0; busy_seen = 1'b0; n0 = nack_cnt;
        i2c_start();
        write_byte({7'h50, 1'b0}, ack);
        check("unmatched_ack", ack, 0);
        check("unmatched_oe_seen", oe_seen, 0);
        check("unmatched_nack_cnt", nack_cnt - n0, 1);
        check("unmatched_busy", busy_seen, 0);
        i2c_stop();
        check("unmatched_busy_after_stop", busy, 0);

        // Basic write
        i2c_start();
        write_byte({7'h44, 1'b0}, ack); check("bw_addr_ack", ack, 1);
        check("bw_busy", busy, 1);
        write_byte(8'h03, ack); check("bw_ptr_ack", ack, 1);
        write_byte(8'hA5, ack); check("bw_d0_ack", ack, 1);
        write_byte(8'h5A, ack); check("bw_d1_ack", ack, 1);
        i2c_stop();
        check("bw_busy_after_stop", busy, 0);
        check("bw_wr_count", wq_addr.size(), 2);
        check("bw_wr0_addr", wq_addr[0], 3); check("bw_wr0_data", wq_data[0], 8'hA5);
        check("bw_wr1_addr", wq_addr[1], 4); check("bw_wr1_data", wq_data[1], 8'h5A);
        wq_addr.delete(); wq_data.delete();

        // Pointer wrap, then out-of-range pointer
        i2c_start();
        write_byte({7'h44, 1'b0}, ack); check("wrap_addr_ack", ack, 1);
        write_byte(8'h0F, ack); check("wrap_ptr_ack", ack, 1);
        write_byte(8'h11, ack); check("wrap_d0_ack", ack, 1);
        write_byte(8'h22, ack); check("wrap_d1_ack", ack, 1);
        write_byte(8'h33, ack); check("wrap_d2_ack", ack, 1);
        i2c_stop();
        check("wrap_wr_count", wq_addr.size(), 3);
        check("wrap_wr0_addr", wq_addr[0], 15);
        check("wrap_wr1_addr", wq_addr[1], 0);
        check("wrap_wr2_addr", wq_addr[2], 1);
        check("wrap_wr2_data", wq_data[2], 8'h33);
        wq_addr.delete(); wq_data.delete();
        n0 = nack_cnt;
        i2c_start();
        write_byte({7'h44, 1'b0}, ack); check("range_addr_ack", ack, 1);
        write_byte(8'h10, ack); check("range_ptr_ack", ack, 0);
        write_byte(8'h99, ack); check("range_data_ack", ack, 0);
        i2c_stop();
        check("range_nack_cnt", nack_cnt - n0, 1);
        check("range_wr_count", wq_addr.size(), 0);

        // Repeated-START read
        i2c_start();
        write_byte({7'h44, 1'b0}, ack); check("rd_waddr_ack", ack, 1);
        write_byte(8'h03, ack); check("rd_ptr_ack", ack, 1);
        i2c_start();
        write_byte({7'h44, 1'b1}, ack); check("rd_raddr_ack", ack, 1);
        read_byte(1'b1, d); check("rd_byte0", d, 8'hA5);
        read_byte(1'b0, d); check("rd_byte1", d, 8'h5A);
        cyc(4);
        check("rd_released_after_nack", oe_a, 0);
        i2c_stop();
        host_addr = 4'd5; host_wdata = 8'hC3; host_we = 1'b1;
        cyc(1);
        host_we = 1'b0;
        i2c_start();
        write_byte({7'h44, 1'b1}, ack); check("rd_ptr5_addr_ack", ack, 1);
        read_byte(1'b0, d); check("rd_ptr_is_5", d, 8'hC3);
        i2c_stop();

        // Host/I2C write collision on reg 4
        wq_addr.delete(); wq_data.delete();
        i2c_start();
        write_byte({7'h44, 1'b0}, ack); check("coll_addr_ack", ack, 1);
        write_byte(8'h04, ack); check("coll_ptr_ack", ack, 1);
        coll = 1'b0;
        fork
            write_byte(8'h77, ack);
            begin
                repeat (8) @(posedge scl_m);
                @(posedge clk); @(posedge clk);
                @(negedge clk);
                host_addr = 4'd4; host_wdata = 8'h11; host_we = 1'b1;
                @(posedge clk);
                @(negedge clk);
                coll = wr_stb && (wr_addr == 4'd4);
                host_we = 1'b0;
            end
        join
        check("coll_data_ack", ack, 1);
        check("coll_same_cycle", coll, 1);
        i2c_stop();
        check("coll_wr_count", wq_addr.size(), 1);

        // Host-side register table
        for (int i = 0; i < 8; i++) begin
            host_addr = hv[i].addr;
            cyc(1);
            check($sformatf("host_rdata[%0d]", hv[i].addr), rdata_a, hv[i].exp);
        end

        // Address mask on the second target
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i2c_start();
            write_byte({mv[i].addr, 1'b0}, ack);
            check($sformatf("mask_ack_%0h", mv[i].addr), ack, mv[i].exp_ack);
            i2c_stop();
        end
        check("mask_nack_cnt", nack_b_cnt, 2);
        check("mask_wr_cnt", wr_b_cnt, 0);
        check("mask_busy_idle", busy_b, 0);
        check("mask_rdata0", rdata_b, 8'h00);
        sel = 1'b0;
        cyc(P);

        // Reset during a driven-low read bit (reg 0 = 0x22, bit 7 = 0)
        i2c_start();
        write_byte({7'h44, 1'b0}, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte({7'h44, 1'b1}, ack); check("rst_rd_addr_ack", ack, 1);
        cyc(3);
        check("rst_rd_bit7_driven", oe_a, 1);
        rst_n = 1'b0;
        #1;
        check("rst_rd_oe_immediate", oe_a, 0);
        for (int i = 0; i < 8; i++) begin
            host_addr = hv[i].addr;
            #1;
            check($sformatf("rst_rd_rdata[%0d]", hv[i].addr), rdata_a, 8'h00);
        end
        cyc(2);
        rst_n = 1'b1;
        scl_m = 1'b1; cyc(P);
        sda_m = 1'b1; cyc(P);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
